mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer output between four requesters. It accepts per-requester request lines, issues a registered one-hot grant, and drives the mux select pair `{CTRL1, CTRL2}` so that the granted requester's input (A, B, C or D for requesters 0..3) appears on the mux `OUT`. A hold limit bounds how long one requester can keep the shared output while others are waiting.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive granted cycles for one owner while any other requester is waiting. Legal range is 1..255.

Ports:
- `CLK` input, 1 bit: single clock. All state changes on the rising edge.
- `RST` input, 1 bit: reset, asynchronous and active-high.
- `EN` input, 1 bit: new-grant enable.
- `REQ` input, 4 bits: `REQ[i]` is the request from requester i; i maps to mux input A/B/C/D.
- `GNT` output, 4 bits: registered one-hot grant, or 0000 when no owner.
- `CTRL1` output, 1 bit: mux select MSB, equal to owner index bit 1.
- `CTRL2` output, 1 bit: mux select LSB, equal to owner index bit 0.
- `BUSY` output, 1 bit: high while a grant is active.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - `OWNER`, 2 bits.
  - `PTR`, 2 bits: round-robin start index.
  - `HOLD`: counter sized to hold `MAX_HOLD`.
- Winner search: the first i with `REQ[i]`=1, scanning PTR, PTR+1, … modulo 4.
- IDLE:
  - `GNT`=0000 and `BUSY`=0.
  - If `EN`=1 and any `REQ` bit is high: go to GRANT. Set `OWNER`=winner, `GNT`=onehot(winner), `{CTRL1,CTRL2}`=winner, `BUSY`=1, `HOLD`=1.
- GRANT, continue: `REQ[OWNER]`=1 and (`HOLD` < `MAX_HOLD` or no other `REQ` bit high). Stay in GRANT; `HOLD` increments and saturates at `MAX_HOLD`.
- GRANT, release: `REQ[OWNER]`=0.
- GRANT, preempt: `REQ[OWNER]`=1, `HOLD`=`MAX_HOLD`, and some other `REQ` bit is high.
- On release or preempt:
  - `PTR` becomes `OWNER`+1 (mod 4).
  - The search runs from `OWNER`+1 and excludes `OWNER`.
  - If a winner exists and `EN`=1: hand over directly. The new grant is issued with `HOLD`=1 and no idle cycle.
  - Otherwise: go to IDLE.
- `EN`=0 blocks new grants only. A current owner keeps its grant until it releases or is preempted, then the arbiter goes to IDLE.
- `{CTRL1,CTRL2}` keep the last owner index in IDLE. Consumers qualify the mux output with `BUSY`.
- Reset (`RST`=1, any time, including mid-grant): immediately force state=IDLE, `GNT`=0000, `CTRL1`=0, `CTRL2`=0, `BUSY`=0, `PTR`=0, `OWNER`=0, `HOLD`=0. Operation resumes on the first rising edge with `RST`=0.

## Timing
- All outputs are registered (Moore); there is no combinational path from `REQ` to any output.
- Grant latency: `REQ` sampled high in IDLE at edge N gives `GNT` valid after edge N.
- `GNT`, `CTRL1`, `CTRL2` and `BUSY` change on the same edge; `GNT` is never multi-hot.
- Handover: the old grant drops and the new grant asserts on the same edge.
- Contended tenure is exactly `MAX_HOLD` cycles. An uncontended owner holds indefinitely.
- Release: the edge that samples `REQ[OWNER]`=0 ends the grant. The owner's last granted cycle is that cycle.
- With `MAX_HOLD`=1 and all four requesting, the grant rotates every cycle.

## Test plan
- **Reset:** assert `RST` mid-grant, between clock edges → `GNT`=0000, `{CTRL1,CTRL2}`=00 and `BUSY`=0 without waiting for an edge. After release with `REQ`=1111, the first grant goes to requester 0.
- **Single request:** `REQ`=0100 with mux inputs A=0, B=1, C=0, D=1 → one edge later `GNT`=0100, `{CTRL1,CTRL2}`=10, `BUSY`=1, and mux `OUT`=0.
- **Full rotation:** `REQ`=1111 held with `MAX_HOLD`=8 → owners 0,1,2,3,0 in turn, each granted for exactly 8 cycles, with no `BUSY`-low gap.
- **Saturation then preempt:** `REQ`=0010 alone for 20 cycles → `GNT` stays 0010. Then `REQ`=1010 → `GNT`=1000 one edge later and `PTR`=2.
- **Release to idle and pointer check:**
  - Owner 0 with `REQ`=0000 → `GNT`=0000 and `BUSY`=0 next edge.
  - Then `REQ`=1001 → `GNT`=1000, since the scan starts at requester 1.
- **Enable gating:** `EN`=0 with `REQ`=1111 in IDLE for 10 cycles → `GNT` stays 0000. `EN` rising → `GNT`=0001 one edge later.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the requester side and the 4:1 mux arbiter.
// The master drives enable and requests; the arbiter (slave) returns grant, mux select and busy.
interface mux4_rr_arbiter_if;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       CTRL1;
  logic       CTRL2;
  logic       BUSY;

  modport master (output EN, REQ, input GNT, CTRL1, CTRL2, BUSY);
  modport slave  (input EN, REQ, output GNT, CTRL1, CTRL2, BUSY);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 mux, with a bounded hold under contention.
// All outputs decode from registered state only, so REQ never reaches an output combinationally.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic CLK,
  input  logic RST,
  mux4_rr_arbiter_if.slave bus
);
  localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_owner, w_owner_nxt;
  logic [1:0]    r_ptr,   w_ptr_nxt;
  logic [HW-1:0] r_hold,  w_hold_nxt;

  logic [3:0]    w_own_oh;
  logic [3:0]    w_others;
  logic [2:0]    w_win_idle;
  logic [2:0]    w_win_hand;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] f_search(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_own_oh   = 4'b0001 << r_owner;
  assign w_others   = bus.REQ & ~w_own_oh;
  assign w_win_idle = f_search(bus.REQ, r_ptr);
  // Handover search starts after the owner and never re-picks it.
  assign w_win_hand = f_search(w_others, r_owner + 2'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      S_IDLE: begin
        if (bus.EN && w_win_idle[2]) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_win_idle[1:0];
          w_hold_nxt  = HW'(1);
        end
      end
      S_GRANT: begin
        if (bus.REQ[r_owner] && ((r_hold < HMAX) || (w_others == 4'b0000))) begin
          if (r_hold < HMAX) w_hold_nxt = r_hold + HW'(1);
        end else begin
          // Release or preempt: pointer moves past the owner either way.
          w_ptr_nxt = r_owner + 2'd1;
          if (bus.EN && w_win_hand[2]) begin
            w_owner_nxt = w_win_hand[1:0];
            w_hold_nxt  = HW'(1);
          end else begin
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Select keeps the last owner while idle; consumers qualify with BUSY.
  always_comb begin
    bus.GNT   = (r_state == S_GRANT) ? w_own_oh : 4'b0000;
    bus.BUSY  = (r_state == S_GRANT);
    bus.CTRL1 = r_owner[1];
    bus.CTRL2 = r_owner[0];
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: a vector table for single-edge behaviour plus hand sequences for
// enable gating, full rotation, saturation/preempt, async reset and MAX_HOLD=1 rotation.
module tb_mux4_rr_arbiter;
  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] mux_in = 4'b1010;  // {D,C,B,A} = 1,0,1,0

  always #5 CLK = ~CLK;

  mux4_rr_arbiter_if ifa ();
  mux4_rr_arbiter_if ifb ();

  mux4_rr_arbiter #(.MAX_HOLD(8)) dut  (.CLK(CLK), .RST(RST), .bus(ifa.slave));
  mux4_rr_arbiter #(.MAX_HOLD(1)) dut1 (.CLK(CLK), .RST(RST), .bus(ifb.slave));

  typedef struct {
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] ctrl;
    logic       bsy;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] g, input logic [1:0] c, input logic b);
    chk({nm, ".gnt"},  ifa.GNT, g);
    chk({nm, ".ctrl"}, {2'b00, ifa.CTRL1, ifa.CTRL2}, {2'b00, c});
    chk({nm, ".busy"}, {3'b000, ifa.BUSY}, {3'b000, b});
  endtask

  initial begin
    logic [1:0] sel;
    logic [3:0] exp_g;

    //          en    req      gnt      ctrl   busy
    vt[0]  = '{1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1};  // single request
    vt[1]  = '{1'b1, 4'b0100, 4'b0100, 2'b10, 1'b1};  // hold
    vt[2]  = '{1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0};  // release, ptr=3
    vt[3]  = '{1'b1, 4'b0011, 4'b0001, 2'b00, 1'b1};  // scan 3,0 -> 0
    vt[4]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0};  // release, ptr=1
    vt[5]  = '{1'b1, 4'b1001, 4'b1000, 2'b11, 1'b1};  // scan from 1 -> 3
    vt[6]  = '{1'b0, 4'b1001, 4'b1000, 2'b11, 1'b1};  // EN=0 keeps owner
    vt[7]  = '{1'b0, 4'b0001, 4'b0000, 2'b11, 1'b0};  // release, no handover while EN=0
    vt[8]  = '{1'b0, 4'b1111, 4'b0000, 2'b11, 1'b0};  // blocked
    vt[9]  = '{1'b1, 4'b1111, 4'b0001, 2'b00, 1'b1};  // ptr=0 -> 0
    vt[10] = '{1'b1, 4'b1110, 4'b0010, 2'b01, 1'b1};  // direct handover
    vt[11] = '{1'b1, 4'b0000, 4'b0000, 2'b01, 1'b0};  // idle

    RST = 1'b1;
    ifa.EN = 1'b0; ifa.REQ = 4'b0000;
    ifb.EN = 1'b1; ifb.REQ = 4'b1111;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset", 4'b0000, 2'b00, 1'b0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ifa.EN  = vt[i].en;
      ifa.REQ = vt[i].req;
      step();
      chk_all($sformatf("vec%0d", i), vt[i].gnt, vt[i].ctrl, vt[i].bsy);
      if (i == 0) begin
        sel = {ifa.CTRL1, ifa.CTRL2};
        chk("vec0.mux_out", {3'b000, mux_in[sel]}, 4'b0000);
      end
    end

    // Enable gating
    do_reset();
    ifa.EN = 1'b0; ifa.REQ = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("gate%0d", i), ifa.GNT, 4'b0000);
    end
    ifa.EN = 1'b1;
    step();
    chk("gate_en.gnt", ifa.GNT, 4'b0001);

    // Full rotation, 8 cycles per owner, no busy gap
    for (int k = 1; k < 40; k++) begin
      step();
      exp_g = 4'b0001 << ((k / 8) % 4);
      chk($sformatf("rot%0d.gnt", k), ifa.GNT, exp_g);
      chk($sformatf("rot%0d.busy", k), {3'b000, ifa.BUSY}, 4'b0001);
    end

    // Saturation, then preempt
    do_reset();
    ifa.EN = 1'b1; ifa.REQ = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("sat%0d", i), ifa.GNT, 4'b0010);
    end
    ifa.REQ = 4'b1010;
    step();
    chk_all("preempt", 4'b1000, 2'b11, 1'b1);

    // Async reset mid-grant, then MAX_HOLD=1 rotation
    do_reset();
    ifa.EN = 1'b1; ifa.REQ = 4'b0100;
    step();
    chk_all("pre_rst", 4'b0100, 2'b10, 1'b1);
    #3;
    RST = 1'b1;
    #1;
    chk_all("async_rst", 4'b0000, 2'b00, 1'b0);
    chk("async_rst.dut1", ifb.GNT, 4'b0000);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ifa.REQ = 4'b1111;
    step();
    chk("post_rst.gnt", ifa.GNT, 4'b0001);
    chk("h1_0", ifb.GNT, 4'b0001);
    for (int k = 1; k < 6; k++) begin
      step();
      exp_g = 4'b0001 << (k % 4);
      chk($sformatf("h1_%0d", k), ifb.GNT, exp_g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
